// File: rtl/wam_pkg.sv
// wam_pkg: shared Whack-A-Mole state type and default sizes
// reused by the sequencer and the score/HEX display blocks.
package wam_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    OVER,
    PAUSE
  } game_state_t;

  localparam int DEF_GAME_SECONDS = 30;
  localparam int DEF_SCORE_W      = 8;

endpackage

// File: rtl/game_sequencer_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchroniser plus rising-edge pulse.
// A button held through reset release never yields a pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [2:0] arm;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
      arm  <= '0;
    end else begin
      s1   <= btn;
      s2   <= s1;
      prev <= s2;
      arm  <= {arm[1:0], 1'b1};
    end
  end

  // edges are only trusted once prev reflects a real sampled level
  assign pulse = arm[2] & s2 & ~prev;

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: Whack-A-Mole round FSM, 1 s timer and score.
// Optional pause key/state built only with WAM_PAUSE_EN defined.
module game_sequencer
  import wam_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int GAME_SECONDS = DEF_GAME_SECONDS,
  parameter int SCORE_W      = DEF_SCORE_W
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               mole_hit,
  input  logic               fi_done,
`ifdef WAM_PAUSE_EN
  input  logic               pause_btn,
`endif
  output logic               game_started,
  output logic               game_over,
  output logic [6:0]         time_left,
  output logic [SCORE_W-1:0] score,
  output logic               sec_tick
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0]      PS_MAX = PW'(CLK_HZ - 1);
  localparam logic [6:0]         T_INIT = 7'(GAME_SECONDS);
  localparam logic [SCORE_W-1:0] S_MAX  = '1;

  game_state_t   state;
  logic [PW-1:0] prescaler;
  logic          fi_low_seen;
  logic          start_ev;
  logic          pause_ev;

  btn_sync_edge u_start (
    .clk   (CLOCK_50),
    .reset (reset),
    .btn   (start_btn),
    .pulse (start_ev)
  );

`ifdef WAM_PAUSE_EN
  btn_sync_edge u_pause (
    .clk   (CLOCK_50),
    .reset (reset),
    .btn   (pause_btn),
    .pulse (pause_ev)
  );
`else
  assign pause_ev = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      game_started <= 1'b0;
      game_over    <= 1'b0;
      time_left    <= T_INIT;
      score        <= '0;
      sec_tick     <= 1'b0;
      prescaler    <= '0;
      fi_low_seen  <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ev && fi_done) begin
            state        <= PLAY;
            game_started <= 1'b1;
            score        <= '0;
            time_left    <= T_INIT;
            prescaler    <= '0;
          end
        end
        PLAY: begin
          // a pause request freezes this cycle entirely
          if (pause_ev) begin
            state <= PAUSE;
          end else begin
            if (mole_hit && score != S_MAX)
              score <= score + 1'b1;
            if (prescaler == PS_MAX) begin
              prescaler <= '0;
              sec_tick  <= 1'b1;
              time_left <= time_left - 1'b1;
              if (time_left == 7'd1) begin
                state        <= OVER;
                game_started <= 1'b0;
                game_over    <= 1'b1;
              end
            end else begin
              prescaler <= prescaler + 1'b1;
            end
          end
        end
        PAUSE: begin
          if (pause_ev)
            state <= PLAY;
        end
        OVER: begin
          if (!fi_done)
            fi_low_seen <= 1'b1;
          // leave only after the FI message has actually been shown
          if (start_ev && fi_low_seen && fi_done) begin
            state       <= IDLE;
            game_over   <= 1'b0;
            fi_low_seen <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
